// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - streams a block of memory bytes into a UART transmitter, one frame per byte
module uart_tx_feeder #(
    parameter int ADDR_WIDTH   = 16,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic                  i_Abort,
    input  logic [ADDR_WIDTH-1:0] i_Base_Addr,
    input  logic [ADDR_WIDTH-1:0] i_Num_Bytes,
    output logic                  o_Mem_Rd_En,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    input  logic [7:0]            i_Mem_Data,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic [ADDR_WIDTH-1:0] o_Byte_Count
);
    localparam int TW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 2;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_LAUNCH,
        S_WAIT_DONE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] r_byte_count;
    logic [TW-1:0]         r_timeout;
    logic                  r_done_prev;
    logic                  r_error;
    logic [7:0]            r_tx_byte;
    logic [ADDR_WIDTH-1:0] w_index_inc;
    logic                  w_done_rise;
    logic                  w_timeout_hit;
    logic                  w_last;
    logic                  w_unused;

    // Frame progress is tracked only through the done edge; active is informational.
    assign w_unused      = i_Tx_Active;
    assign w_index_inc   = r_index + ADDR_WIDTH'(1);
    assign w_done_rise   = i_Tx_Done & ~r_done_prev;
    assign w_timeout_hit = (r_timeout == TIMEOUT_LAST);
    assign w_last        = (w_index_inc == r_count);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_Mem_Rd_En  = 1'b0;
        o_Tx_DV      = 1'b1;
        o_Done       = 1'b0;
        o_Busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    w_next_state = (i_Num_Bytes == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                o_Mem_Rd_En  = 1'b1;
                w_next_state = S_LATCH;
            end
            S_LATCH:  w_next_state = S_LAUNCH;
            S_LAUNCH: begin
                o_Tx_DV      = 1'b0;
                w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_done_rise) begin
                    w_next_state = S_NEXT;
                end else if (w_timeout_hit) begin
                    w_next_state = S_DONE;
                end
            end
            S_NEXT: begin
                w_next_state = (w_last || i_Abort) ? S_DONE : S_READ;
            end
            S_DONE: begin
                o_Done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_base       <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_byte_count <= '0;
            r_timeout    <= '0;
            r_done_prev  <= 1'b0;
            r_error      <= 1'b0;
            r_tx_byte    <= '0;
        end else begin
            r_done_prev <= i_Tx_Done;
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_base       <= i_Base_Addr;
                        r_count      <= i_Num_Bytes;
                        r_index      <= '0;
                        r_error      <= 1'b0;
                        r_byte_count <= '0;
                    end
                end
                S_LATCH:  r_tx_byte <= i_Mem_Data;
                S_LAUNCH: r_timeout <= '0;
                S_WAIT_DONE: begin
                    // A done flag held high for several cycles must count as one frame.
                    if (w_done_rise) begin
                        r_byte_count <= r_byte_count + ADDR_WIDTH'(1);
                    end else if (w_timeout_hit) begin
                        r_error <= 1'b1;
                    end else begin
                        r_timeout <= r_timeout + TW'(1);
                    end
                end
                S_NEXT:  r_index <= w_index_inc;
                default: ;
            endcase
        end
    end

    assign o_Mem_Addr   = r_base + r_index;
    assign o_Tx_Byte    = r_tx_byte;
    assign o_Error      = r_error;
    assign o_Byte_Count = r_byte_count;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder with a serial transmitter/receiver model
module tb_uart_tx_feeder;
    localparam int CPB      = 87;
    localparam int TO_MAIN  = 2048;
    localparam int TO_SHORT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, start2;
    logic [15:0] base, num, base2, num2;
    logic        rd_en, dv, busy, done, err;
    logic [15:0] addr, bcnt;
    logic [7:0]  txb;
    logic [7:0]  mem_q  = 8'h00;
    logic        rd_en2, dv2, busy2, done2, err2;
    logic [15:0] addr2, bcnt2;
    logic [7:0]  txb2;
    logic [7:0]  mem_q2 = 8'h00;
    logic        zero   = 1'b0;

    logic [7:0]  mem [0:65535];

    logic        tx_done   = 1'b0;
    logic        tx_active = 1'b0;
    logic        tx_line   = 1'b1;
    logic [9:0]  tx_frame  = 10'h3FF;
    int          tx_left = 0, tx_tick = 0, tx_hold_cnt = 0, hold_len = 2;

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    int dv_pulses = 0, done_pulses = 0, rd_cnt = 0, last_bcnt = 0;
    int bc_steps[$];
    logic [15:0] rd_addrs[$];
    logic [7:0]  rx_q[$];

    uart_tx_feeder #(.ADDR_WIDTH(16), .TIMEOUT_CLKS(TO_MAIN)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Abort(abort),
        .i_Base_Addr(base), .i_Num_Bytes(num),
        .o_Mem_Rd_En(rd_en), .o_Mem_Addr(addr), .i_Mem_Data(mem_q),
        .o_Tx_DV(dv), .o_Tx_Byte(txb), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Busy(busy), .o_Done(done), .o_Error(err), .o_Byte_Count(bcnt)
    );

    uart_tx_feeder #(.ADDR_WIDTH(16), .TIMEOUT_CLKS(TO_SHORT)) dut_to (
        .i_Clock(clk), .i_Reset(rst), .i_Start(start2), .i_Abort(zero),
        .i_Base_Addr(base2), .i_Num_Bytes(num2),
        .o_Mem_Rd_En(rd_en2), .o_Mem_Addr(addr2), .i_Mem_Data(mem_q2),
        .o_Tx_DV(dv2), .o_Tx_Byte(txb2), .i_Tx_Active(zero), .i_Tx_Done(zero),
        .o_Busy(busy2), .o_Done(done2), .o_Error(err2), .o_Byte_Count(bcnt2)
    );

    always @(posedge clk) begin
        if (rd_en)  mem_q  <= mem[addr];
        if (rd_en2) mem_q2 <= mem[addr2];
    end

    // Transmitter: 10-bit frame, done held for hold_len cycles after the stop bit.
    always @(posedge clk) begin
        if (tx_hold_cnt > 0) begin
            tx_hold_cnt <= tx_hold_cnt - 1;
            if (tx_hold_cnt == 1) tx_done <= 1'b0;
        end
        if (tx_left > 0) begin
            if (tx_tick == CPB - 1) begin
                tx_tick  <= 0;
                tx_left  <= tx_left - 1;
                tx_frame <= {1'b1, tx_frame[9:1]};
                tx_line  <= tx_frame[1];
                if (tx_left == 1) begin
                    tx_done     <= 1'b1;
                    tx_active   <= 1'b0;
                    tx_hold_cnt <= hold_len;
                    tx_line     <= 1'b1;
                end
            end else begin
                tx_tick <= tx_tick + 1;
            end
        end else if (dv === 1'b0) begin
            tx_frame  <= {1'b1, txb, 1'b0};
            tx_line   <= 1'b0;
            tx_left   <= 10;
            tx_tick   <= 0;
            tx_active <= 1'b1;
        end
    end

    initial begin : rx
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_line == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_line;
                end
                repeat (CPB) @(negedge clk);
                if (tx_line == 1'b1) rx_q.push_back(b);
            end
        end
    end

    // Timeline model: cycle numbers at which each output event must occur.
    bit          m_valid = 1'b0, m_busy, m_err, m_wait, m_next, m_prev;
    int          m_cnt, m_n, m_base, m_idx, m_wcnt;
    int          m_done_at, m_rd_at, m_launch_at, m_next_at;
    logic [7:0]  m_txb;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_err = 1'b0; m_wait = 1'b0; m_next = 1'b0;
            m_cnt = 0; m_n = 0; m_base = 0; m_idx = 0; m_wcnt = 0;
            m_done_at = -10; m_rd_at = -10; m_launch_at = -10; m_next_at = -10;
            m_txb = 8'h00; m_prev = 1'b0;
        end else begin
            if (m_busy && cyc == m_done_at + 1) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    m_base = int'(base); m_n = int'(num);
                    m_err = 1'b0; m_cnt = 0; m_idx = 0; m_busy = 1'b1;
                    m_wait = 1'b0; m_next = 1'b0;
                    if (m_n == 0) m_done_at = cyc;
                    else begin m_rd_at = cyc; m_launch_at = cyc + 2; end
                end
            end else begin
                if (m_next && cyc == m_next_at + 1) begin
                    m_next = 1'b0;
                    m_idx++;
                    if (m_idx == m_n || abort) m_done_at = cyc;
                    else begin m_rd_at = cyc; m_launch_at = cyc + 2; end
                end
                if (m_wait) begin
                    m_wcnt++;
                    if (tx_done && !m_prev) begin
                        m_cnt++; m_wait = 1'b0; m_next = 1'b1; m_next_at = cyc;
                    end else if (m_wcnt == TO_MAIN) begin
                        m_err = 1'b1; m_wait = 1'b0; m_done_at = cyc;
                    end
                end
                if (cyc == m_launch_at) m_txb = mem[16'((m_base + m_idx) & 16'hFFFF)];
                if (cyc == m_launch_at + 1) begin m_wait = 1'b1; m_wcnt = 0; end
            end
            m_prev = tx_done;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", busy, m_busy);
            check("done", done, cyc == m_done_at);
            check("tx_dv", dv, cyc != m_launch_at);
            check("mem_rd_en", rd_en, cyc == m_rd_at);
            if (cyc == m_rd_at) check("mem_addr", addr, (m_base + m_idx) & 16'hFFFF);
            check("error", err, m_err);
            check("byte_count", bcnt, m_cnt);
            check("tx_byte", txb, m_txb);
        end
        if (dv === 1'b0) dv_pulses++;
        if (done === 1'b1) done_pulses++;
        if (rd_en === 1'b1) begin rd_cnt++; rd_addrs.push_back(addr); end
        if (int'(bcnt) != last_bcnt) begin
            last_bcnt = int'(bcnt);
            if (last_bcnt != 0) bc_steps.push_back(last_bcnt);
        end
    end

    task automatic start_xfer(input logic [15:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        dv_pulses = 0; done_pulses = 0; rd_cnt = 0;
        bc_steps.delete(); rd_addrs.delete(); rx_q.delete();
        base = b; num = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        int c;
        c = 0;
        while (done !== 1'b1 && c < maxc) begin @(negedge clk); c++; end
        check(name, done, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_dv_pulses(input int n, input int maxc, input string name);
        int c;
        c = 0;
        while (dv_pulses < n && c < maxc) begin @(posedge clk); c++; end
        check(name, dv_pulses >= n, 1'b1);
        #1;
    endtask

    task automatic check_rx3(input string name);
        check({name, "_rx_count"}, rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check({name, "_rx0"}, rx_q[0], 8'hA5);
            check({name, "_rx1"}, rx_q[1], 8'h3C);
            check({name, "_rx2"}, rx_q[2], 8'hFF);
        end
    endtask

    initial begin
        int c, launch_cyc, done_cyc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C; mem[16'h0012] = 8'hFF;
        mem[16'hFFFF] = 8'h77; mem[16'h0000] = 8'h88;

        rst = 1'b1; start = 1'b1; abort = 1'b0; base = 16'h0010; num = 16'd3;
        start2 = 1'b0; base2 = 16'h0; num2 = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_dv", dv, 1'b1);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_addr", addr, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", err, 1'b0);
        check("rst_bcnt", bcnt, 16'h0);
        check("rst_tx_byte", txb, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);

        start_xfer(16'h0010, 16'd3);
        wait_done(5000, "n3_done_seen");
        check("n3_dv_pulses", dv_pulses, 3);
        check("n3_done_pulses", done_pulses, 1);
        check("n3_error", err, 1'b0);
        check("n3_bcnt", bcnt, 16'd3);
        check("n3_steps", bc_steps.size(), 3);
        if (bc_steps.size() == 3) begin
            check("n3_step0", bc_steps[0], 1);
            check("n3_step1", bc_steps[1], 2);
            check("n3_step2", bc_steps[2], 3);
        end
        check_rx3("n3");

        start_xfer(16'h0040, 16'd0);
        @(negedge clk);
        check("n0_done_next_cycle", done, 1'b1);
        repeat (5) @(negedge clk);
        check("n0_rd_count", rd_cnt, 0);
        check("n0_dv_pulses", dv_pulses, 0);
        check("n0_done_pulses", done_pulses, 1);
        check("n0_bcnt", bcnt, 16'd0);

        start_xfer(16'h0030, 16'd5);
        wait_dv_pulses(2, 3000, "abort_second_launch");
        abort = 1'b1;
        wait_done(3000, "abort_done_seen");
        abort = 1'b0;
        check("abort_bcnt", bcnt, 16'd2);
        check("abort_dv_pulses", dv_pulses, 2);
        check("abort_done_pulses", done_pulses, 1);

        @(posedge clk);
        #1 base2 = 16'h0010; num2 = 16'd1; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        c = 0;
        while (dv2 !== 1'b0 && c < 20) begin @(negedge clk); c++; end
        check("to_launch_seen", dv2, 1'b0);
        launch_cyc = cyc;
        c = 0;
        while (done2 !== 1'b1 && c < 200) begin @(negedge clk); c++; end
        check("to_done_seen", done2, 1'b1);
        done_cyc = cyc;
        check("to_latency", done_cyc - launch_cyc, 65);
        check("to_error", err2, 1'b1);
        check("to_bcnt", bcnt2, 16'd0);
        @(negedge clk);
        check("to_idle", busy2, 1'b0);
        check("to_error_sticky", err2, 1'b1);
        @(posedge clk);
        #1 num2 = 16'd0; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        @(negedge clk);
        check("to_error_cleared", err2, 1'b0);
        check("to_restart_done", done2, 1'b1);

        hold_len = 5;
        start_xfer(16'h0010, 16'd3);
        wait_dv_pulses(1, 100, "hold_first_launch");
        @(posedge clk);
        #1 base = 16'h0050; num = 16'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(5000, "hold_done_seen");
        check("hold_bcnt", bcnt, 16'd3);
        check("hold_dv_pulses", dv_pulses, 3);
        check("hold_done_pulses", done_pulses, 1);
        check_rx3("hold");

        hold_len = 2;
        start_xfer(16'hFFFF, 16'd2);
        wait_done(4000, "wrap_done_seen");
        check("wrap_rd_count", rd_addrs.size(), 2);
        if (rd_addrs.size() == 2) begin
            check("wrap_addr0", rd_addrs[0], 16'hFFFF);
            check("wrap_addr1", rd_addrs[1], 16'h0000);
        end
        check("wrap_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("wrap_rx0", rx_q[0], 8'h77);
            check("wrap_rx1", rx_q[1], 8'h88);
        end
        check("wrap_bcnt", bcnt, 16'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Upstream stage of the UART transmitter. It streams a block of bytes, e.g. downsampled output samples, from a synchronous byte memory into the transmitter, one byte per UART frame.
- On a start pulse it reads bytes from a base address one at a time, presents each byte, launches the frame with an active-low data-valid strobe, and waits for frame completion.
- Reports busy, done, error and progress to the control logic.

Parameters:
- ADDR_WIDTH, 16: width of memory address, base address and byte count.
- TIMEOUT_CLKS, 2048: maximum clocks from launch to transmitter done before declaring an error. Must exceed 10*CLKS_PER_BIT of the transmitter.

Ports:
- i_Clock  in  1  system clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Start  in  1  one-cycle start request; sampled only in IDLE.
- i_Abort  in  1  stop after the byte currently in flight; level, sampled in NEXT.
- i_Base_Addr  in  ADDR_WIDTH  first memory address; latched at start.
- i_Num_Bytes  in  ADDR_WIDTH  byte count; latched at start; 0 means no transfer.
- o_Mem_Rd_En  out  1  memory read enable.
- o_Mem_Addr  out  ADDR_WIDTH  memory read address.
- i_Mem_Data  in  8  memory read data; valid the cycle after o_Mem_Rd_En.
- o_Tx_DV  out  1  active-low launch strobe to the transmitter; idles high.
- o_Tx_Byte  out  8  byte presented to the transmitter.
- i_Tx_Active  in  1  transmitter frame in progress (informational, unused for sequencing).
- i_Tx_Done  in  1  transmitter done flag; high for 2 or more cycles per frame.
- o_Busy  out  1  high whenever state is not IDLE.
- o_Done  out  1  one-cycle pulse at end of transfer (normal, zero-length, abort or timeout).
- o_Error  out  1  sticky timeout flag; cleared by reset or the next accepted start.
- o_Byte_Count  out  ADDR_WIDTH  bytes completed in the current or last transfer.

Behaviour:
- Reset values (next edge with i_Reset=1): state IDLE; o_Tx_DV=1; o_Mem_Rd_En=0; o_Mem_Addr=0; o_Tx_Byte=0; o_Busy=0; o_Done=0; o_Error=0; o_Byte_Count=0; internal index, edge register and timeout counter = 0.
- Reset mid-transfer: same values immediately, no further strobe. A frame already launched in the transmitter is not recalled.
- States: IDLE, READ, LATCH, LAUNCH, WAIT_DONE, NEXT, DONE.
- IDLE:
  - i_Start=1 latches base and count, clears o_Error and o_Byte_Count.
  - Count != 0 goes to READ; count 0 goes directly to DONE.
  - Start is ignored in every other state.
- READ: o_Mem_Rd_En=1, o_Mem_Addr=base+index (mod 2^ADDR_WIDTH, wraps silently). Goes to LATCH.
- LATCH: o_Tx_Byte <= i_Mem_Data; o_Mem_Rd_En=0. Goes to LAUNCH. o_Tx_Byte holds until the next LATCH.
- LAUNCH: o_Tx_DV=0 for exactly this one cycle, otherwise always 1. Clears the timeout counter. Goes to WAIT_DONE.
- WAIT_DONE:
  - Advance only on a rising edge of i_Tx_Done (registered previous value 0, current 1), so the multi-cycle done high counts once.
  - On the edge: o_Byte_Count+1, go to NEXT.
  - Timeout counter increments each cycle. Reaching TIMEOUT_CLKS-1 without the edge sets o_Error=1 and goes to DONE.
- NEXT:
  - index+1.
  - If index+1 == count, or i_Abort=1, go to DONE; else go to READ.
- DONE: o_Done=1 for this one cycle; go to IDLE.
- Latency:
  - Start to first DV low: 3 cycles (start edge, then READ, LATCH, LAUNCH).
  - Done edge to next DV low: 4 cycles (NEXT, READ, LATCH, LAUNCH).
  - The transmitter is back in idle by then, so no frame is lost.
- Simultaneous events:
  - i_Abort and last byte in NEXT: single DONE.
  - i_Reset wins over everything.
  - i_Start during DONE is ignored.

Test Plan:
1. Reset with i_Start=1 asserted: all outputs at reset values, o_Tx_DV=1, no memory read.
2. Memory preloaded 0x10=0xA5, 0x11=0x3C, 0x12=0xFF; base=0x10, N=3; transmitter model with CLKS_PER_BIT=87:
   - Exactly 3 DV-low pulses, each one cycle wide.
   - Serial line decodes A5, 3C, FF.
   - o_Byte_Count steps 1, 2, 3.
   - One o_Done pulse; o_Error=0.
3. N=0: o_Done one cycle after the start edge; no o_Mem_Rd_En; o_Tx_DV stays 1; o_Byte_Count=0.
4. N=5, i_Abort raised during byte 2: transfer ends after byte 2 completes; o_Byte_Count=2; one o_Done.
5. Transmitter model never asserts done, TIMEOUT_CLKS=64: o_Error=1 and o_Done after 64 WAIT_DONE cycles. The next start clears o_Error.
6. i_Tx_Done held high 5 cycles per frame, plus a second start pulse mid-transfer: each byte counted once; the second start is ignored. Separately, base=0xFFFF, N=2: reads 0xFFFF then 0x0000.
